// File: rtl/jtag_tap_mchain.sv
// jtag_tap_mchain
// IEEE 1149.1 TAP controller with a parametrised instruction register, NUM_CHAINS
// external data-register chains, internal IDCODE and BYPASS registers, and a
// registered TDO with output enable.
//
// Ports
//   tclk_i        test clock (state on rising edge, TDO/tdo_en on falling edge)
//   trst_i        asynchronous active-high reset
//   tms_i, tdi_i  test mode select / serial data in, sampled on rising tclk_i
//   chain_tdo_i   serial out of each external chain
//   chain_sel_o   one-hot select of the active external chain (0 for IDCODE/BYPASS)
//   capture_dr_o, shift_dr_o, update_dr_o
//                 DR strobes, active only when an external chain is selected
//   instr_o       current (updated) instruction
//   tap_state_o   current TAP state encoding
//   tdo_o, tdo_en_o
//                 serial data out and its enable
module jtag_tap_mchain #(
    parameter int          IR_W       = 4,
    parameter int          NUM_CHAINS = 3,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                  tclk_i,
    input  logic                  trst_i,
    input  logic                  tms_i,
    input  logic                  tdi_i,
    input  logic [NUM_CHAINS-1:0] chain_tdo_i,
    output logic [NUM_CHAINS-1:0] chain_sel_o,
    output logic                  capture_dr_o,
    output logic                  shift_dr_o,
    output logic                  update_dr_o,
    output logic [IR_W-1:0]       instr_o,
    output logic [3:0]            tap_state_o,
    output logic                  tdo_o,
    output logic                  tdo_en_o
);

    // state  | meaning
    // TLR    | test-logic-reset, instruction forced to IDCODE
    // RTI    | run-test/idle
    // SEL_DR | select DR scan
    // CAP_DR | capture into selected DR
    // SH_DR  | shift selected DR
    // EX1_DR | exit1 DR
    // PA_DR  | pause DR
    // EX2_DR | exit2 DR
    // UPD_DR | update DR
    // SEL_IR | select IR scan
    // CAP_IR | capture 0..01 into IR shift register
    // SH_IR  | shift IR
    // EX1_IR | exit1 IR
    // PA_IR  | pause IR
    // EX2_IR | exit2 IR
    // UPD_IR | copy IR shift register into instruction
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PA_DR  = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IDCODE_OP = IR_W'(NUM_CHAINS);
    localparam logic [IR_W-1:0] IR_CAPT   = {{(IR_W-1){1'b0}}, 1'b1};

    tap_state_t      state_q, state_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic [IR_W-1:0] instr_q, instr_d;
    logic            bypass_q, bypass_d;
    logic [31:0]     idcode_sr_q, idcode_sr_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;

    logic                  sel_ext;
    logic                  sel_idcode;
    logic [NUM_CHAINS-1:0] chain_sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms_i ? TLR    : RTI;
            RTI:    state_d = tms_i ? SEL_DR : RTI;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
        endcase
    end

    // Decode from the registered instruction only, so chain_sel cannot move
    // during a DR scan.
    always_comb begin
        chain_sel = '0;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            chain_sel[k] = (instr_q == IR_W'(k));
        end
    end
    assign sel_ext    = |chain_sel;
    assign sel_idcode = (instr_q == IDCODE_OP);

    always_comb begin
        ir_sr_d     = ir_sr_q;
        instr_d     = instr_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;

        if (state_q == CAP_IR) ir_sr_d = IR_CAPT;
        if (state_q == SH_IR)  ir_sr_d = {tdi_i, ir_sr_q[IR_W-1:1]};

        // Going into TLR takes priority; UPD_IR never leads to TLR anyway.
        if (state_d == TLR)          instr_d = IDCODE_OP;
        else if (state_q == UPD_IR)  instr_d = ir_sr_q;

        if (state_q == CAP_DR) begin
            bypass_d    = 1'b0;
            idcode_sr_d = IDCODE_VAL;
        end
        if (state_q == SH_DR) begin
            if (sel_idcode)    idcode_sr_d = {tdi_i, idcode_sr_q[31:1]};
            else if (!sel_ext) bypass_d    = tdi_i;
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = (state_q == SH_DR) || (state_q == SH_IR);
        if (state_q == SH_IR) begin
            tdo_d = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_ext)         tdo_d = |(chain_tdo_i & chain_sel);
            else if (sel_idcode) tdo_d = idcode_sr_q[0];
            else                 tdo_d = bypass_q;
        end
    end

    always_ff @(posedge tclk_i or posedge trst_i) begin
        if (trst_i) begin
            state_q     <= TLR;
            ir_sr_q     <= '0;
            instr_q     <= IDCODE_OP;
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_sr_q     <= ir_sr_d;
            instr_q     <= instr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
        end
    end

    // Falling-edge launch gives the far-end device half a cycle of setup.
    always_ff @(negedge tclk_i or posedge trst_i) begin
        if (trst_i) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign chain_sel_o  = chain_sel;
    assign capture_dr_o = (state_q == CAP_DR) && sel_ext;
    assign shift_dr_o   = (state_q == SH_DR)  && sel_ext;
    assign update_dr_o  = (state_q == UPD_DR) && sel_ext;
    assign instr_o      = instr_q;
    assign tap_state_o  = state_q;
    assign tdo_o        = tdo_q;
    assign tdo_en_o     = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_mchain.sv
module tb_jtag_tap_mchain;

    logic       tclk = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic [2:0] chain_tdo;
    logic [2:0] chain_sel;
    logic       capture_dr, shift_dr, update_dr;
    logic [3:0] instr;
    logic [3:0] tap_state;
    logic       tdo, tdo_en;

    int checks = 0;
    int errors = 0;

    jtag_tap_mchain #(.IR_W(4), .NUM_CHAINS(3), .IDCODE_VAL(32'h1000_0001)) dut (
        .tclk_i      (tclk),
        .trst_i      (trst),
        .tms_i       (tms),
        .tdi_i       (tdi),
        .chain_tdo_i (chain_tdo),
        .chain_sel_o (chain_sel),
        .capture_dr_o(capture_dr),
        .shift_dr_o  (shift_dr),
        .update_dr_o (update_dr),
        .instr_o     (instr),
        .tap_state_o (tap_state),
        .tdo_o       (tdo),
        .tdo_en_o    (tdo_en)
    );

    always #5 tclk = ~tclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK: inputs set while clock is low, return 1 time unit after the
    // following falling edge so both rising- and falling-edge outputs are settled.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tclk);
        @(negedge tclk);
        #1;
    endtask

    // From RTI: load an IR value LSB first, finish back in RTI.
    task automatic load_ir(input logic [3:0] v);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, v[i]);
        step(1, 0);
        step(0, 0);
    endtask

    function automatic logic [2:0] chains(input logic b);
        return {~b, b, ~b};
    endfunction

    logic [31:0] rx;
    logic [7:0]  pat;
    logic        ok;

    initial begin
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; chain_tdo = 3'b000;
        #12;
        chk("rst_state",  32'(tap_state), 32'hF);
        chk("rst_instr",  32'(instr),     32'h3);
        chk("rst_tdo",    32'(tdo),       32'h0);
        chk("rst_tdo_en", 32'(tdo_en),    32'h0);
        chk("rst_sel",    32'(chain_sel), 32'h0);
        trst = 1'b0;

        // IDCODE readout
        step(0, 0); step(1, 0); step(0, 0);
        chk("cap_dr_state", 32'(tap_state), 32'h6);
        chk("cap_dr_en",    32'(tdo_en),    32'h0);
        chk("cap_dr_strobe_idcode", 32'(capture_dr), 32'h0);
        step(0, 0);
        chk("sh_dr_state", 32'(tap_state), 32'h2);
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rx[i] = tdo;
            ok &= tdo_en;
            step(i == 31, 0);
        end
        chk("idcode_serial", rx, 32'h1000_0001);
        chk("idcode_en_in_shift", 32'(ok), 32'h1);
        chk("ex1_dr_state", 32'(tap_state), 32'h1);
        chk("ex1_dr_en",    32'(tdo_en),    32'h0);

        // Back into SH_DR, then five TMS=1
        step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("sh_dr_again", 32'(tap_state), 32'h2);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        chk("four_tms_sel_ir", 32'(tap_state), 32'h4);
        step(1, 0);
        chk("five_tms_tlr",   32'(tap_state), 32'hF);
        chk("five_tms_instr", 32'(instr),     32'h3);

        // IR = F, BYPASS
        step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        chk("cap_ir_state", 32'(tap_state), 32'hE);
        step(0, 0);
        chk("sh_ir_en", 32'(tdo_en), 32'h1);
        rx = '0;
        for (int i = 0; i < 4; i++) begin
            rx[i] = tdo;
            step(i == 3, 1);
        end
        chk("ir_capture_out", rx, 32'h1);
        chk("ex1_ir_state", 32'(tap_state), 32'h9);
        step(1, 0);
        chk("upd_ir_state", 32'(tap_state), 32'hD);
        chk("instr_before_upd", 32'(instr), 32'h3);
        step(0, 0);
        chk("instr_bypass", 32'(instr),     32'hF);
        chk("sel_bypass",   32'(chain_sel), 32'h0);
        step(1, 0); step(0, 0); step(0, 0);
        rx = '0;
        rx[0] = tdo; step(0, 1);
        rx[1] = tdo; step(0, 0);
        rx[2] = tdo; step(0, 1);
        rx[3] = tdo;
        chk("bypass_serial", rx, 32'hA);
        step(1, 0); step(1, 0); step(0, 0);
        chk("rti_state", 32'(tap_state), 32'hC);

        // IR = 1, external chain 1
        load_ir(4'h1);
        chk("instr_chain1", 32'(instr),     32'h1);
        chk("sel_chain1",   32'(chain_sel), 32'h2);
        step(1, 0);
        chk("sel_dr_no_cap", 32'(capture_dr), 32'h0);
        pat = 8'b1011_0010;
        chain_tdo = chains(pat[0]);
        step(0, 0);
        chk("chain_capture", 32'(capture_dr), 32'h1);
        chk("chain_no_shift_in_cap", 32'(shift_dr), 32'h0);
        step(0, 0);
        chk("chain_cap_drop", 32'(capture_dr), 32'h0);
        rx = '0;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx[i] = tdo;
            ok &= shift_dr;
            ok &= (chain_sel == 3'b010);
            if (i < 7) chain_tdo = chains(pat[i+1]);
            step(i == 7, 0);
        end
        chk("chain1_tdo", rx, 32'(pat));
        chk("chain1_shift_sel_stable", 32'(ok), 32'h1);
        chk("chain1_shift_end", 32'(shift_dr), 32'h0);
        chk("chain1_ex1_no_upd", 32'(update_dr), 32'h0);
        step(1, 0);
        chk("chain1_update", 32'(update_dr), 32'h1);
        step(0, 0);
        chk("chain1_update_end", 32'(update_dr), 32'h0);

        // IR = 7, unused opcode behaves as BYPASS
        load_ir(4'h7);
        chk("instr_unused", 32'(instr),     32'h7);
        chk("sel_unused",   32'(chain_sel), 32'h0);
        chain_tdo = 3'b111;
        step(1, 0); step(0, 0);
        chk("unused_no_cap", 32'(capture_dr), 32'h0);
        step(0, 0);
        chk("unused_no_shift", 32'(shift_dr), 32'h0);
        chk("unused_first_tdo", 32'(tdo), 32'h0);
        step(0, 1);
        chk("unused_bypass_tdo", 32'(tdo), 32'h1);
        step(1, 0); step(1, 0);
        chk("unused_upd_state", 32'(tap_state), 32'h5);
        chk("unused_no_upd",    32'(update_dr), 32'h0);
        step(1, 0); step(1, 0); step(1, 0);
        chk("tms_tlr_reload_state", 32'(tap_state), 32'hF);
        chk("tms_tlr_reload_instr", 32'(instr),     32'h3);

        // IR = 2, abort SH_DR with TRST
        step(0, 0);
        load_ir(4'h2);
        chk("sel_chain2", 32'(chain_sel), 32'h4);
        chain_tdo = 3'b100;
        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        chk("chain2_shift", 32'(shift_dr), 32'h1);
        chk("chain2_tdo",   32'(tdo),      32'h1);
        trst = 1'b1;
        #1;
        chk("abort_state",  32'(tap_state), 32'hF);
        chk("abort_tdo",    32'(tdo),       32'h0);
        chk("abort_tdo_en", 32'(tdo_en),    32'h0);
        chk("abort_instr",  32'(instr),     32'h3);
        chk("abort_sel",    32'(chain_sel), 32'h0);
        #2;
        trst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            ok &= ~update_dr;
            ok &= (tap_state == 4'hF);
        end
        chk("abort_no_update", 32'(ok), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
